// File: rtl/core_boot_loader.sv
// core_boot_loader
// ----------------
// Stream-fed program loader that sits in front of riscv_core. It receives a
// framed program image on a valid/ready word stream and writes it into the
// core's instruction memory. It then pulses pc_we/pc_i to start the core at
// the load address.
//
// Frame layout: MAGIC, byte base address, word count N, N data words
// (and, with BOOT_CHECKSUM_EN defined, one trailing checksum word equal to
// base ^ N ^ data[0] ^ ... ^ data[N-1]).
//
// Optional feature macro: BOOT_CHECKSUM_EN (checksum word plus S_CSUM state).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_valid/s_ready/s_data  input word stream
//   reload                leave RUN or ERROR and return to IDLE
//   imem_we/addr/wdata    instruction memory write port (1-cycle latency)
//   pc_we/pc_i            one-cycle PC load strobe and start address
//   core_run              core released
//   load_err              sticky frame error (cleared by reload)
//   loaded_cnt            words written in the current frame
module core_boot_loader #(
  parameter int          DATA_WIDTH = 32,
  parameter int          IMEM_DEPTH = 1024,
  parameter logic [31:0] MAGIC      = 32'hB007_C0DE,
  localparam int         IDX_W      = $clog2(IMEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [IDX_W-1:0]      imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  pc_we,
  output logic [DATA_WIDTH-1:0] pc_i,
  output logic                  core_run,
  output logic                  load_err,
  output logic [IDX_W:0]        loaded_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_COUNT,
    S_DATA,
`ifdef BOOT_CHECKSUM_EN
    S_CSUM,
`endif
    S_LAUNCH,
    S_RUN,
    S_ERROR
  } state_t;

  // State entered once the payload is complete.
`ifdef BOOT_CHECKSUM_EN
  localparam state_t S_POST = S_CSUM;
`else
  localparam state_t S_POST = S_LAUNCH;
`endif

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] base_reg, base_next;
  logic [IDX_W:0]        remaining_reg, remaining_next;
  logic [IDX_W:0]        loaded_cnt_reg, loaded_cnt_next;
  logic                  s_ready_reg, s_ready_next;
  logic                  imem_we_reg, imem_we_next;
  logic [IDX_W-1:0]      imem_addr_reg, imem_addr_next;
  logic [DATA_WIDTH-1:0] imem_wdata_reg, imem_wdata_next;
  logic                  pc_we_reg, pc_we_next;
  logic [DATA_WIDTH-1:0] pc_i_reg, pc_i_next;
  logic                  core_run_reg, core_run_next;
  logic                  load_err_reg, load_err_next;
`ifdef BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_reg, csum_next;
`endif

  logic                  hs;
  logic [IDX_W-1:0]      base_idx;
  logic [DATA_WIDTH-1:0] room;

  assign hs       = s_valid && s_ready_reg;
  // Only meaningful once base has passed the range check in S_ADDR.
  assign base_idx = base_reg[IDX_W+1:2];
  assign room     = DATA_WIDTH'(IMEM_DEPTH) - DATA_WIDTH'(base_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      base_reg       <= '0;
      remaining_reg  <= '0;
      loaded_cnt_reg <= '0;
      s_ready_reg    <= 1'b0;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= '0;
      pc_we_reg      <= 1'b0;
      pc_i_reg       <= '0;
      core_run_reg   <= 1'b0;
      load_err_reg   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_reg       <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      base_reg       <= base_next;
      remaining_reg  <= remaining_next;
      loaded_cnt_reg <= loaded_cnt_next;
      s_ready_reg    <= s_ready_next;
      imem_we_reg    <= imem_we_next;
      imem_addr_reg  <= imem_addr_next;
      imem_wdata_reg <= imem_wdata_next;
      pc_we_reg      <= pc_we_next;
      pc_i_reg       <= pc_i_next;
      core_run_reg   <= core_run_next;
      load_err_reg   <= load_err_next;
`ifdef BOOT_CHECKSUM_EN
      csum_reg       <= csum_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    base_next       = base_reg;
    remaining_next  = remaining_reg;
    loaded_cnt_next = loaded_cnt_reg;
    imem_we_next    = 1'b0;
    imem_addr_next  = imem_addr_reg;
    imem_wdata_next = imem_wdata_reg;
    pc_i_next       = pc_i_reg;
`ifdef BOOT_CHECKSUM_EN
    csum_next       = csum_reg;
`endif

    case (state_reg)
      S_IDLE: begin
        if (hs && s_data == DATA_WIDTH'(MAGIC)) state_next = S_ADDR;
      end
      S_ADDR: begin
        if (hs) begin
          base_next = s_data;
          if (s_data[1:0] != 2'b00 || (s_data >> 2) >= DATA_WIDTH'(IMEM_DEPTH))
            state_next = S_ERROR;
          else
            state_next = S_COUNT;
        end
      end
      S_COUNT: begin
        if (hs) begin
`ifdef BOOT_CHECKSUM_EN
          csum_next = base_reg ^ s_data;
`endif
          // Bounding N by the room above base means the index never wraps.
          if (s_data > room) begin
            state_next = S_ERROR;
          end else if (s_data == '0) begin
            state_next = S_POST;
          end else begin
            remaining_next = s_data[IDX_W:0];
            state_next     = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (hs) begin
          imem_we_next    = 1'b1;
          imem_addr_next  = base_idx + loaded_cnt_reg[IDX_W-1:0];
          imem_wdata_next = s_data;
          loaded_cnt_next = loaded_cnt_reg + 1'b1;
          remaining_next  = remaining_reg - 1'b1;
`ifdef BOOT_CHECKSUM_EN
          csum_next       = csum_reg ^ s_data;
`endif
          if (remaining_reg == 1) state_next = S_POST;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CSUM: begin
        if (hs) state_next = (s_data == csum_reg) ? S_LAUNCH : S_ERROR;
      end
`endif
      S_LAUNCH: state_next = S_RUN;
      S_RUN:    if (reload) state_next = S_IDLE;
      S_ERROR:  if (reload) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase

    // Every return to IDLE starts a fresh frame count.
    if (state_next == S_IDLE) loaded_cnt_next = '0;
    if (state_next == S_LAUNCH) pc_i_next = base_reg;

    // Status outputs are registered copies of the state being entered.
    s_ready_next  = (state_next == S_IDLE) || (state_next == S_ADDR) ||
                    (state_next == S_COUNT) || (state_next == S_DATA)
`ifdef BOOT_CHECKSUM_EN
                    || (state_next == S_CSUM)
`endif
                    ;
    pc_we_next    = (state_next == S_LAUNCH);
    core_run_next = (state_next == S_RUN);
    load_err_next = (state_next == S_ERROR);
  end

  assign s_ready    = s_ready_reg;
  assign imem_we    = imem_we_reg;
  assign imem_addr  = imem_addr_reg;
  assign imem_wdata = imem_wdata_reg;
  assign pc_we      = pc_we_reg;
  assign pc_i       = pc_i_reg;
  assign core_run   = core_run_reg;
  assign load_err   = load_err_reg;
  assign loaded_cnt = loaded_cnt_reg;

endmodule

// File: tb/tb_core_boot_loader.sv
// Testbench for core_boot_loader: directed frames with hand-computed
// expectations. The driver queues the expected imem writes and PC launches
// as it issues stimulus; a monitor pops and compares them whenever the DUT
// shows imem_we or pc_we.
module tb_core_boot_loader;
  localparam logic [31:0] MAGIC = 32'hB007_C0DE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        reload = 1'b0;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        pc_we;
  logic [31:0] pc_i;
  logic        core_run;
  logic        load_err;
  logic [10:0] loaded_cnt;

  core_boot_loader dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .pc_we(pc_we), .pc_i(pc_i), .core_run(core_run),
    .load_err(load_err), .loaded_cnt(loaded_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  idx;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] pq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] dat [0:7];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write / launch the DUT shows must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL imem_write unexpected idx=%0d data=%h", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = wq.pop_front();
        if (imem_addr !== e.idx || imem_wdata !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL imem_write got idx=%0d data=%h cyc=%0d want idx=%0d data=%h cyc=%0d",
                   imem_addr, imem_wdata, cyc, e.idx, e.data, e.cyc);
        end else
          $display("write idx=%0d data=%h cyc=%0d ok", imem_addr, imem_wdata, cyc);
      end
    end
    if (rst_n && pc_we) begin
      checks++;
      if (pq.size() == 0) begin
        errors++;
        $display("FAIL pc_we unexpected pc_i=%h", pc_i);
      end else begin
        logic [31:0] ep;
        ep = pq.pop_front();
        if (pc_i !== ep) begin
          errors++;
          $display("FAIL pc_launch got pc_i=%h want %h", pc_i, ep);
        end else
          $display("launch pc_i=%h ok", pc_i);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end else
      $display("check %s = %h ok", name, act);
  endtask

  // Present one word from a negedge; returns at the negedge after its transfer.
  task automatic send(input logic [31:0] d, input bit is_data, input logic [9:0] idx);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout word=%h s_ready stuck low", d);
      s_valid = 1'b0;
      return;
    end
    if (is_data) wq.push_back('{idx: idx, data: d, cyc: cyc + 1});
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  // Full good frame from dat[]; checks the launch and the RUN state.
  task automatic load_frame(input logic [31:0] base, input int n, input bit gaps);
    logic [31:0] cs;
    cs = base ^ 32'(n);
    pq.push_back(base);
    send(MAGIC, 1'b0, '0);
    send(base, 1'b0, '0);
    send(32'(n), 1'b0, '0);
    for (int i = 0; i < n; i++) begin
      send(dat[i], 1'b1, 10'(base >> 2) + 10'(i));
      cs = cs ^ dat[i];
      if (gaps) idle_cycle();
    end
`ifdef BOOT_CHECKSUM_EN
    send(cs, 1'b0, '0);
`endif
    @(negedge clk);
    chk("core_run_after_launch", {31'b0, core_run}, 32'd1);
    chk("loaded_cnt_after_launch", {21'b0, loaded_cnt}, 32'(n));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, {31'b0, s_ready}, 32'd0);
    chk({tag, "_imem_we"}, {31'b0, imem_we}, 32'd0);
    chk({tag, "_imem_addr"}, {22'b0, imem_addr}, 32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_pc_we"}, {31'b0, pc_we}, 32'd0);
    chk({tag, "_pc_i"}, pc_i, 32'd0);
    chk({tag, "_core_run"}, {31'b0, core_run}, 32'd0);
    chk({tag, "_load_err"}, {31'b0, load_err}, 32'd0);
    chk({tag, "_loaded_cnt"}, {21'b0, loaded_cnt}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_after_reset", {31'b0, s_ready}, 32'd1);

    // Nominal load: base 0, three words.
    dat[0] = 32'h002081b3; dat[1] = 32'h06408213; dat[2] = 32'h0200A283;
    load_frame(32'h0, 3, 1'b0);
    chk("nominal_pc_i", pc_i, 32'h0);
    do_reload();
    chk("reload_core_run", {31'b0, core_run}, 32'd0);
    chk("reload_loaded_cnt", {21'b0, loaded_cnt}, 32'd0);
    chk("reload_s_ready", {31'b0, s_ready}, 32'd1);

    // Garbage word dropped, then offset frame at byte 0x10 (index 4).
    send(32'h12345678, 1'b0, '0);
    dat[0] = 32'h000F5337;
    load_frame(32'h10, 1, 1'b0);
    @(negedge clk);
    chk("offset_pc_i_held", pc_i, 32'h10);
    do_reload();

    // Misaligned base.
    send(MAGIC, 1'b0, '0);
    send(32'h6, 1'b0, '0);
    chk("misalign_load_err", {31'b0, load_err}, 32'd1);
    chk("misalign_s_ready", {31'b0, s_ready}, 32'd0);
    chk("misalign_core_run", {31'b0, core_run}, 32'd0);
    do_reload();
    chk("misalign_reload_err", {31'b0, load_err}, 32'd0);
    chk("misalign_reload_ready", {31'b0, s_ready}, 32'd1);

    // Count overruns the top of memory: index 1023 leaves room for one word.
    send(MAGIC, 1'b0, '0);
    send(32'hFFC, 1'b0, '0);
    chk("top_base_ok_ready", {31'b0, s_ready}, 32'd1);
    send(32'd2, 1'b0, '0);
    chk("overrun_load_err", {31'b0, load_err}, 32'd1);
    do_reload();
    chk("overrun_reload_err", {31'b0, load_err}, 32'd0);

    // Gaps between data words at byte 0x40 (indices 16..19).
    dat[0] = 32'h11111111; dat[1] = 32'h22222222;
    dat[2] = 32'h33333333; dat[3] = 32'h44444444;
    load_frame(32'h40, 4, 1'b1);
    do_reload();

    // Empty frame launches at byte 0x8.
    load_frame(32'h8, 0, 1'b0);
    do_reload();

    // Asynchronous reset after two of four data words.
    send(MAGIC, 1'b0, '0);
    send(32'h20, 1'b0, '0);
    send(32'd4, 1'b0, '0);
    send(32'hA0A0A0A0, 1'b1, 10'd8);
    send(32'hB1B1B1B1, 1'b1, 10'd9);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midframe_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    dat[0] = 32'hCAFEF00D; dat[1] = 32'h0BADBEEF;
    load_frame(32'h0, 2, 1'b0);
    do_reload();

`ifdef BOOT_CHECKSUM_EN
    // Checksum good: 0 ^ 1 ^ FF = FE.
    pq.push_back(32'h0);
    send(MAGIC, 1'b0, '0);
    send(32'h0, 1'b0, '0);
    send(32'd1, 1'b0, '0);
    send(32'h000000FF, 1'b1, 10'd0);
    send(32'h000000FE, 1'b0, '0);
    @(negedge clk);
    chk("csum_good_core_run", {31'b0, core_run}, 32'd1);
    do_reload();
    // Checksum bad: error, no launch expected.
    send(MAGIC, 1'b0, '0);
    send(32'h0, 1'b0, '0);
    send(32'd1, 1'b0, '0);
    send(32'h000000FF, 1'b1, 10'd0);
    send(32'h00000000, 1'b0, '0);
    chk("csum_bad_load_err", {31'b0, load_err}, 32'd1);
    @(negedge clk);
    chk("csum_bad_core_run", {31'b0, core_run}, 32'd0);
    do_reload();
`endif

    repeat (3) @(negedge clk);
    chk("pending_writes", 32'(wq.size()), 32'd0);
    chk("pending_launches", 32'(pq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
